// File: rtl/dispatch_buffer.sv
// In-order dispatch buffer between rename and the ALU/MEM reservation stations, with CDB/commit wakeup snooping.
// Optional stall counter: define DISPATCH_STALL_STATS_EN to add the stall_cycles port.
`default_nettype none

package uarch_pkg;
    localparam int PIPE_WIDTH = 2;
    localparam int XLEN       = 32;
    localparam int TAG_WIDTH  = 6;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic                 is_renamed;
        logic [TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
    } src_operand_t;

    typedef struct packed {
        logic                 is_valid;
        logic [6:0]           opcode;
        logic [TAG_WIDTH-1:0] dest_tag;
        src_operand_t         src_0_a;
        src_operand_t         src_0_b;
        src_operand_t         src_1_a;
        src_operand_t         src_1_b;
    } instruction_t;

    typedef struct packed {
        logic                 we;
        logic [TAG_WIDTH-1:0] tag;
        logic [XLEN-1:0]      data;
    } prf_commit_write_port_t;
endpackage

module dispatch_buffer
    import uarch_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CDB_PORTS = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    output logic                                    dispatch_rdy,
    input  instruction_t [PIPE_WIDTH-1:0]           renamed_insts,
    input  prf_commit_write_port_t [PIPE_WIDTH-1:0] commit_write_ports,
    input  logic [CDB_PORTS-1:0]                    cdb_valid,
    input  logic [CDB_PORTS-1:0][TAG_WIDTH-1:0]     cdb_tag,
    input  logic [CDB_PORTS-1:0][XLEN-1:0]          cdb_data,
    input  logic [1:0]                              alu_free,
    input  logic [1:0]                              mem_free,
    output instruction_t [PIPE_WIDTH-1:0]           alu_insts,
    output instruction_t [PIPE_WIDTH-1:0]           mem_insts
`ifdef DISPATCH_STALL_STATS_EN
    ,
    output logic [31:0]                             stall_cycles
`endif
);

    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SLOT_W = $clog2(PIPE_WIDTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] PW_C    = CNT_W'(PIPE_WIDTH);

    logic [PTR_W-1:0]              head_q, head_d;
    logic [PTR_W-1:0]              tail_q, tail_d;
    logic [CNT_W-1:0]              count_q, count_d;
    instruction_t                  mem_q [BUF_DEPTH];
    instruction_t                  mem_d [BUF_DEPTH];

    logic                          dispatch_rdy_s;
    logic [CNT_W-1:0]              n_enq_s;
    logic [CNT_W-1:0]              n_deq_s;
    logic [PTR_W-1:0]              wptr_s;
    logic [PTR_W-1:0]              win_idx_s;
    instruction_t                  cand_s;
    logic                          is_mem_s;
    logic                          can_s;
    logic                          blocked_s;
    logic [SLOT_W-1:0]             alu_used_s;
    logic [SLOT_W-1:0]             mem_used_s;
    instruction_t [PIPE_WIDTH-1:0] alu_insts_s;
    instruction_t [PIPE_WIDTH-1:0] mem_insts_s;

    // Lowest-index CDB port wins, then lowest-index commit port; a hit clears the tag and rename bit.
    function automatic src_operand_t snoop_src(
        input src_operand_t                            s,
        input logic [CDB_PORTS-1:0]                    v,
        input logic [CDB_PORTS-1:0][TAG_WIDTH-1:0]     t,
        input logic [CDB_PORTS-1:0][XLEN-1:0]          d,
        input prf_commit_write_port_t [PIPE_WIDTH-1:0] c
    );
        src_operand_t r;
        logic         hit;
        logic         m;
        r   = s;
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            m      = s.is_renamed && v[p] && (t[p] == s.tag) && !hit;
            r.data = m ? d[p] : r.data;
            hit    = hit | m;
        end
        for (int p = 0; p < PIPE_WIDTH; p++) begin
            m      = s.is_renamed && c[p].we && (c[p].tag == s.tag) && !hit;
            r.data = m ? c[p].data : r.data;
            hit    = hit | m;
        end
        r.is_renamed = s.is_renamed & ~hit;
        r.tag        = hit ? {TAG_WIDTH{1'b0}} : s.tag;
        return r;
    endfunction

    function automatic instruction_t snoop_inst(
        input instruction_t                            inst,
        input logic [CDB_PORTS-1:0]                    v,
        input logic [CDB_PORTS-1:0][TAG_WIDTH-1:0]     t,
        input logic [CDB_PORTS-1:0][XLEN-1:0]          d,
        input prf_commit_write_port_t [PIPE_WIDTH-1:0] c
    );
        instruction_t r;
        r         = inst;
        r.src_0_a = snoop_src(inst.src_0_a, v, t, d, c);
        r.src_0_b = snoop_src(inst.src_0_b, v, t, d, c);
        r.src_1_a = snoop_src(inst.src_1_a, v, t, d, c);
        r.src_1_b = snoop_src(inst.src_1_b, v, t, d, c);
        return r;
    endfunction

    // Ready uses the start-of-cycle occupancy only; enqueue count is zero when not ready.
    always_comb begin
        dispatch_rdy_s = ((DEPTH_C - count_q) >= PW_C);
        n_enq_s        = {CNT_W{1'b0}};
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            n_enq_s = n_enq_s + CNT_W'(renamed_insts[i].is_valid);
        end
        n_enq_s = dispatch_rdy_s ? n_enq_s : {CNT_W{1'b0}};
    end

    // Oldest-first dispatch window; the first entry that cannot go blocks everything younger.
    always_comb begin
        blocked_s   = 1'b0;
        alu_used_s  = {SLOT_W{1'b0}};
        mem_used_s  = {SLOT_W{1'b0}};
        n_deq_s     = {CNT_W{1'b0}};
        alu_insts_s = '0;
        mem_insts_s = '0;
        win_idx_s   = {PTR_W{1'b0}};
        cand_s      = '0;
        is_mem_s    = 1'b0;
        can_s       = 1'b0;
        for (int k = 0; k < PIPE_WIDTH; k++) begin
            win_idx_s = head_q + PTR_W'(k);
            cand_s    = snoop_inst(mem_q[win_idx_s], cdb_valid, cdb_tag, cdb_data, commit_write_ports);
            is_mem_s  = (cand_s.opcode == OPC_LOAD) || (cand_s.opcode == OPC_STORE);
            can_s     = !blocked_s && !flush && (CNT_W'(k) < count_q) &&
                        (is_mem_s ? (mem_used_s < SLOT_W'(mem_free)) : (alu_used_s < SLOT_W'(alu_free)));
            if (can_s) begin
                if (is_mem_s) begin
                    mem_insts_s[mem_used_s[SLOT_W-2:0]] = cand_s;
                    mem_used_s = mem_used_s + SLOT_W'(1);
                end else begin
                    alu_insts_s[alu_used_s[SLOT_W-2:0]] = cand_s;
                    alu_used_s = alu_used_s + SLOT_W'(1);
                end
                n_deq_s = n_deq_s + CNT_W'(1);
            end else begin
                blocked_s = 1'b1;
            end
        end
    end

    // Next storage image: every stored entry is snooped, then incoming entries are snooped and written.
    always_comb begin
        wptr_s = {PTR_W{1'b0}};
        for (int e = 0; e < BUF_DEPTH; e++) begin
            mem_d[e] = snoop_inst(mem_q[e], cdb_valid, cdb_tag, cdb_data, commit_write_ports);
        end
        for (int i = 0; i < PIPE_WIDTH; i++) begin
            wptr_s = tail_q + PTR_W'(i);
            if (dispatch_rdy_s && renamed_insts[i].is_valid) begin
                mem_d[wptr_s]          = snoop_inst(renamed_insts[i], cdb_valid, cdb_tag, cdb_data,
                                                    commit_write_ports);
                mem_d[wptr_s].is_valid = 1'b1;
            end else begin
                mem_d[wptr_s] = mem_d[wptr_s];
            end
        end
        count_d = count_q + n_enq_s - n_deq_s;
        head_d  = head_q + PTR_W'(n_deq_s);
        tail_d  = tail_q + PTR_W'(n_enq_s);
    end

    // FIFO state; flush empties the buffer ahead of any enqueue or dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            for (int e = 0; e < BUF_DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else if (flush) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

`ifdef DISPATCH_STALL_STATS_EN
    logic [31:0] stall_q;

    // Saturating count of occupied cycles with no dispatch; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if ((count_q != {CNT_W{1'b0}}) && (n_deq_s == {CNT_W{1'b0}}) &&
                     (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end else begin
            stall_q <= stall_q;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign dispatch_rdy = dispatch_rdy_s;
    assign alu_insts    = alu_insts_s;
    assign mem_insts    = mem_insts_s;

endmodule

`default_nettype wire
